// File: rtl/rx_frame_sequencer.sv
// rtl/rx_frame_sequencer.sv - serial frame receive sequencer driving an external shift register and receive buffer
module rx_frame_sequencer #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic serial_in,
    input  logic data_read,
    output logic sync_bit,
    output logic shift_strobe,
    output logic load_buffer,
    output logic data_ready,
    output logic overrun_error,
    output logic framing_error,
    output logic busy
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START_CHK,
        SAMPLE,
        STOP_CHK,
        LOAD
    } state_t;

    state_t        state;
    logic          meta;
    logic          prev_bit;
    logic [TW-1:0] timer;
    logic [BW-1:0] bit_cnt;
    logic          start_edge;
    logic          half_end;
    logic          period_end;
    logic          load_now;
    logic          overrun_set;

    assign start_edge   = prev_bit & ~sync_bit;
    assign half_end     = (timer == HALF_END);
    assign period_end   = (timer == BIT_END);
    assign shift_strobe = (state == SAMPLE) && period_end;
    assign load_now     = (state == LOAD);
    assign load_buffer  = load_now;
    assign busy         = (state != IDLE);
    assign overrun_set  = load_now & data_ready & ~data_read;

    // Line idles high, so the synchroniser and edge history reset to 1 to avoid a false start.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            meta     <= 1'b1;
            sync_bit <= 1'b1;
            prev_bit <= 1'b1;
        end else begin
            meta     <= serial_in;
            sync_bit <= meta;
            prev_bit <= sync_bit;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            timer         <= '0;
            bit_cnt       <= '0;
            framing_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timer   <= '0;
                    bit_cnt <= '0;
                    if (start_edge) begin
                        framing_error <= 1'b0;
                        state         <= START_CHK;
                    end
                end
                START_CHK: begin
                    if (half_end) begin
                        timer <= '0;
                        state <= sync_bit ? IDLE : SAMPLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                SAMPLE: begin
                    if (period_end) begin
                        timer   <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= STOP_CHK;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP_CHK: begin
                    if (period_end) begin
                        timer <= '0;
                        if (sync_bit) begin
                            state <= LOAD;
                        end else begin
                            framing_error <= 1'b1;
                            state         <= IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                LOAD: begin
                    timer <= '0;
                    state <= IDLE;
                end
                default: begin
                    timer <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // A load wins over a same-cycle read: the new word is valid and nothing was lost.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            if (load_now) begin
                data_ready <= 1'b1;
            end else if (data_read) begin
                data_ready <= 1'b0;
            end
            if (overrun_set) begin
                overrun_error <= 1'b1;
            end else if (data_read) begin
                overrun_error <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rx_frame_sequencer.sv
// tb/tb_rx_frame_sequencer.sv - scoreboard bench for rx_frame_sequencer
module tb_rx_frame_sequencer;
    localparam int C = 10;
    localparam int D = 8;
    localparam int H = C / 2;

    logic clk = 1'b0;
    logic n_rst;
    logic serial_in;
    logic data_read;
    logic sync_bit;
    logic shift_strobe;
    logic load_buffer;
    logic data_ready;
    logic overrun_error;
    logic framing_error;
    logic busy;

    rx_frame_sequencer #(.CLKS_PER_BIT(C), .DATA_BITS(D)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .serial_in     (serial_in),
        .data_read     (data_read),
        .sync_bit      (sync_bit),
        .shift_strobe  (shift_strobe),
        .load_buffer   (load_buffer),
        .data_ready    (data_ready),
        .overrun_error (overrun_error),
        .framing_error (framing_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; bit is_load; bit val; } ev_t;
    typedef struct { int cyc; bit val; } fe_t;
    typedef struct { int s; int e; } span_t;

    ev_t   ev_q[$];
    int    load_q[$];
    fe_t   fe_q[$];
    span_t busy_q[$];
    int    read_q[$];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    bit exp_ready, exp_ovr, exp_fe;
    bit rd_rand_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: compares DUT outputs against the queued expectations every cycle.
    initial begin
        bit ld_now, exp_busy, rd;
        exp_ready = 1'b0;
        exp_ovr   = 1'b0;
        exp_fe    = 1'b0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                ev_q.delete();
                load_q.delete();
                fe_q.delete();
                busy_q.delete();
                exp_ready = 1'b0;
                exp_ovr   = 1'b0;
                exp_fe    = 1'b0;
                check("reset_outputs",
                      {sync_bit, shift_strobe, load_buffer, data_ready, overrun_error, framing_error, busy},
                      7'b1000000);
            end else begin
                while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
                    check("missed_event_cycle", cyc, ev_q[0].cyc);
                    void'(ev_q.pop_front());
                end
                if (shift_strobe || load_buffer) begin
                    check("strobe_load_exclusive", shift_strobe & load_buffer, 0);
                    if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
                        check("event_kind_load", load_buffer, ev_q[0].is_load);
                        if (!ev_q[0].is_load) check("strobe_sync_bit", sync_bit, ev_q[0].val);
                        void'(ev_q.pop_front());
                    end else begin
                        check("unexpected_event_cycle", cyc, (ev_q.size() > 0) ? ev_q[0].cyc : -1);
                    end
                end

                exp_busy = (busy_q.size() > 0) && (cyc >= busy_q[0].s) && (cyc <= busy_q[0].e);
                check("busy", busy, exp_busy);
                if (busy_q.size() > 0 && cyc >= busy_q[0].e) void'(busy_q.pop_front());

                while (fe_q.size() > 0 && fe_q[0].cyc <= cyc) begin
                    exp_fe = fe_q[0].val;
                    void'(fe_q.pop_front());
                end
                check("framing_error", framing_error, exp_fe);
                check("data_ready", data_ready, exp_ready);
                check("overrun_error", overrun_error, exp_ovr);

                while (load_q.size() > 0 && load_q[0] < cyc) void'(load_q.pop_front());
                ld_now = (load_q.size() > 0) && (load_q[0] == cyc);
                if (ld_now) void'(load_q.pop_front());
                rd = data_read;
                if (ld_now && exp_ready && !rd) exp_ovr = 1'b1;
                else if (rd) exp_ovr = 1'b0;
                if (ld_now) exp_ready = 1'b1;
                else if (rd) exp_ready = 1'b0;
            end
        end
    end

    initial begin
        data_read = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            data_read = 1'b0;
            while (read_q.size() > 0 && read_q[0] < cyc) void'(read_q.pop_front());
            if (read_q.size() > 0 && read_q[0] == cyc) begin
                data_read = 1'b1;
                void'(read_q.pop_front());
            end else if (rd_rand_en && $urandom_range(0, 11) == 0) begin
                data_read = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic read_pulse();
        read_q.push_back(cyc + 1);
        tick(3);
    endtask

    // Frame drawn on the line from this cycle; expectations follow from the bit timing rules.
    task automatic send_frame(input logic [15:0] data, input bit stop_val, input bit read_on_load,
                              input int abort_at);
        int n, e, t;
        ev_t ev;
        fe_t f;
        span_t s;
        n = cyc;
        e = n + 2;
        t = e + H + (D + 1) * C;
        f.cyc = e + 1;
        f.val = 1'b0;
        fe_q.push_back(f);
        for (int k = 1; k <= D; k++) begin
            ev.cyc = e + H + k * C;
            ev.is_load = 1'b0;
            ev.val = data[k-1];
            ev_q.push_back(ev);
        end
        s.s = e + 1;
        if (stop_val) begin
            ev.cyc = t + 1;
            ev.is_load = 1'b1;
            ev.val = 1'b0;
            ev_q.push_back(ev);
            load_q.push_back(t + 1);
            s.e = t + 1;
            if (read_on_load) read_q.push_back(t + 1);
        end else begin
            f.cyc = t + 1;
            f.val = 1'b1;
            fe_q.push_back(f);
            s.e = t;
        end
        busy_q.push_back(s);
        for (int i = 0; i < (D + 2) * C; i++) begin
            if (abort_at >= 0 && i == abort_at) begin
                n_rst = 1'b0;
                serial_in = 1'b1;
                tick(3);
                n_rst = 1'b1;
                tick(4);
                return;
            end
            if (i < C) serial_in = 1'b0;
            else if (i < (D + 1) * C) serial_in = data[i/C-1];
            else serial_in = stop_val;
            tick(1);
        end
        serial_in = 1'b1;
        if (!stop_val) tick(3);
    endtask

    task automatic glitch(input int len);
        fe_t f;
        span_t s;
        int e;
        e = cyc + 2;
        f.cyc = e + 1;
        f.val = 1'b0;
        fe_q.push_back(f);
        s.s = e + 1;
        s.e = e + H;
        busy_q.push_back(s);
        serial_in = 1'b0;
        tick(len);
        serial_in = 1'b1;
        tick(H + 6);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation reached cycle %0d, limit 200000", cyc);
        $fatal(1);
    end

    initial begin
        int r;
        logic [15:0] dv;
        n_rst = 1'b0;
        serial_in = 1'b1;
        tick(3);
        n_rst = 1'b1;
        tick(5);

        send_frame(16'h00A5, 1'b1, 1'b0, -1);
        tick(10);
        read_pulse();
        glitch(3);
        send_frame(16'h003C, 1'b0, 1'b0, -1);
        tick(5);
        send_frame(16'h005A, 1'b1, 1'b0, -1);
        read_pulse();

        send_frame(16'h00C3, 1'b1, 1'b0, H + 3 * C + 4);
        send_frame(16'h0096, 1'b1, 1'b0, -1);
        read_pulse();

        send_frame(16'h0011, 1'b1, 1'b0, -1);
        send_frame(16'h0022, 1'b1, 1'b0, -1);
        tick(5);
        read_pulse();

        send_frame(16'h0033, 1'b1, 1'b0, -1);
        send_frame(16'h0044, 1'b1, 1'b1, -1);
        tick(5);
        read_pulse();

        rd_rand_en = 1'b1;
        for (int it = 0; it < 30; it++) begin
            r = $urandom_range(0, 7);
            if (r == 0) begin
                glitch($urandom_range(1, H - 1));
            end else begin
                dv = 16'($urandom_range(0, (1 << D) - 1));
                send_frame(dv, r != 1, $urandom_range(0, 3) == 0, -1);
            end
            tick($urandom_range(0, 6));
        end
        rd_rand_en = 1'b0;
        tick(60);

        check("pending_events", ev_q.size(), 0);
        check("pending_loads", load_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
